vector_loader: RTL and testbench

- Upstream feeder for the 8-lane signed max-reduction pipeline.
- Accepts a serial stream of signed samples over a valid/ready handshake and assembles them into full 8-lane vectors.
- Emits each completed vector as a one-cycle valid pulse, directly driving the pipeline's lane inputs and valid_in.
- Frame end (s_last) flushes a partial vector, padded with the most negative value so pad lanes never win a max comparison.

---
 rtl/vector_loader.sv | 124 ++++++++++++
 tb/tb_vector_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vector_loader.sv
// vector_loader: assembles a serial stream of signed samples into LANES-wide
// vectors for the signed max-reduction pipeline. A frame end (s_last) flushes
// a partial vector whose unused lanes hold the most negative value, so pad
// lanes can never win a max comparison downstream.
module vector_loader #(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  localparam int CW   = $clog2(LANES)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic [LANES*WIDTH-1:0] vec_data,
  output logic                   vec_valid,
  output logic [CW:0]            vec_count,
  output logic                   vec_last
);

  localparam logic [WIDTH-1:0] PAD = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] lanes_q [LANES];
  logic             ready_q;
  logic             accept;
  logic             complete;

  assign s_ready  = ready_q;
  assign accept   = s_valid && ready_q;
  assign complete = accept && (s_last || (count_q == CW'(LANES - 1)));

  // Ready drops only for the cycle following a reset edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // State and lane-counter register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state and next lane index; a completing sample returns to IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept && !complete) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (complete) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Assembly register: each accepted sample lands in the lane the counter selects.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else if (accept) begin
      lanes_q[count_q] <= s_data;
    end
  end

  // Output register: snapshot the assembly lanes plus the completing sample, pad the rest.
  always_ff @(posedge clock) begin
    if (rst) begin
      vec_valid <= 1'b0;
      vec_data  <= '0;
      vec_count <= '0;
      vec_last  <= 1'b0;
    end else begin
      vec_valid <= complete;
      if (complete) begin
        for (int i = 0; i < LANES; i++) begin
          if (i < int'(count_q)) begin
            vec_data[i*WIDTH +: WIDTH] <= lanes_q[i];
          end else if (i == int'(count_q)) begin
            vec_data[i*WIDTH +: WIDTH] <= s_data;
          end else begin
            vec_data[i*WIDTH +: WIDTH] <= PAD;
          end
        end
        vec_count <= (CW+1)'(count_q) + 1'b1;
        vec_last  <= s_last;
      end
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// tb_vector_loader: directed vectors with hand-computed expected lanes for
// vector_loader at the default 8 x 8-bit configuration.
module tb_vector_loader;

  logic        clock;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [63:0] vec_data;
  logic        vec_valid;
  logic [3:0]  vec_count;
  logic        vec_last;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  count;
    logic        last;
    int          cycle;
  } pulse_t;

  pulse_t pulses[$];
  int     cycleCount = 0;
  int     lastAccept = 0;
  int     checkCount = 0;
  int     passCount  = 0;

  vector_loader #(.WIDTH(8), .LANES(8)) dut (
    .clock     (clock),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .vec_data  (vec_data),
    .vec_valid (vec_valid),
    .vec_count (vec_count),
    .vec_last  (vec_last)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle stamp and capture of every output pulse, sampled just after the edge.
  always @(posedge clock) begin
    pulse_t p;
    cycleCount = cycleCount + 1;
    #1;
    if (vec_valid === 1'b1) begin
      p.data  = vec_data;
      p.count = vec_count;
      p.last  = vec_last;
      p.cycle = cycleCount;
      pulses.push_back(p);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last);
    @(negedge clock);
    if (valid) begin
      checkOutput("s_ready", 64'(s_ready), 64'd1);
      lastAccept = cycleCount + 1;
    end
    s_valid = valid;
    s_data  = data;
    s_last  = last;
  endtask

  task automatic idleCycles(input int n);
    @(negedge clock);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic resetDut();
    @(negedge clock);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clock);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_vec_valid", 64'(vec_valid), 64'd0);
    checkOutput("rst_vec_data", vec_data, 64'd0);
    checkOutput("rst_vec_count", 64'(vec_count), 64'd0);
    checkOutput("rst_vec_last", 64'(vec_last), 64'd0);
    rst = 1'b0;
  endtask

  task automatic popVector(input string tag, input logic [63:0] expData,
                           input logic [3:0] expCount, input logic expLast,
                           output int stamp);
    pulse_t p;
    stamp = -1;
    if (pulses.size() == 0) begin
      checkOutput({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      p = pulses.pop_front();
      stamp = p.cycle;
      checkOutput({tag, "_data"}, p.data, expData);
      checkOutput({tag, "_count"}, 64'(p.count), 64'(expCount));
      checkOutput({tag, "_last"}, 64'(p.last), 64'(expLast));
    end
  endtask

  initial begin
    int          stamp;
    int          stamp2;
    int          accept1;
    logic [7:0]  vals [8];
    logic signed [7:0] maxVal;
    logic signed [7:0] lane;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    repeat (2) @(negedge clock);
    resetDut();

    vals = '{8'h01, 8'hFE, 8'h03, 8'hFC, 8'h05, 8'hFA, 8'h07, 8'hF8};
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, vals[i], 1'b0);
    idleCycles(3);
    checkOutput("t1_pulses", 64'(pulses.size()), 64'd1);
    checkOutput("t1_hold_data", vec_data, 64'hF807FA05FC03FE01);
    checkOutput("t1_hold_valid", 64'(vec_valid), 64'd0);
    popVector("t1", 64'hF807FA05FC03FE01, 4'd8, 1'b0, stamp);
    checkOutput("t1_latency", 64'(stamp), 64'(lastAccept));

    applyStimulus(1'b1, 8'd10, 1'b0);
    applyStimulus(1'b1, 8'd20, 1'b0);
    applyStimulus(1'b1, 8'd30, 1'b1);
    idleCycles(3);
    checkOutput("t2_pulses", 64'(pulses.size()), 64'd1);
    maxVal = -8'sd128;
    for (int i = 0; i < 8; i++) begin
      lane = vec_data[i*8 +: 8];
      if (lane > maxVal) maxVal = lane;
    end
    checkOutput("t2_max", 64'(maxVal), 64'(8'sd30));
    popVector("t2", 64'h80808080801E140A, 4'd3, 1'b1, stamp);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (i == 8) accept1 = lastAccept;
    end
    idleCycles(3);
    checkOutput("t3_pulses", 64'(pulses.size()), 64'd2);
    popVector("t3a", 64'h0807060504030201, 4'd8, 1'b0, stamp);
    popVector("t3b", 64'h100F0E0D0C0B0A09, 4'd8, 1'b0, stamp2);
    checkOutput("t3a_latency", 64'(stamp), 64'(accept1));
    checkOutput("t3_spacing", 64'(stamp2 - stamp), 64'd8);

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i * 3), i == 8);
    idleCycles(3);
    popVector("t3c", 64'h1815120F0C090603, 4'd8, 1'b1, stamp);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h21 + i), 1'b0);
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h7F, 1'b0);
    idleCycles(3);
    checkOutput("t4_pulses", 64'(pulses.size()), 64'd1);
    popVector("t4", 64'h7F7F7F7F7F7F7F7F, 4'd8, 1'b0, stamp);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(17 * (i + 1)), 1'b0);
      if (i < 7) applyStimulus(1'b0, 8'hAA, 1'b1);
    end
    idleCycles(3);
    checkOutput("t5_pulses", 64'(pulses.size()), 64'd1);
    popVector("t5", 64'h8877665544332211, 4'd8, 1'b0, stamp);
    checkOutput("t5_latency", 64'(stamp), 64'(lastAccept));

    applyStimulus(1'b1, 8'h80, 1'b1);
    idleCycles(3);
    checkOutput("t6_pulses", 64'(pulses.size()), 64'd1);
    popVector("t6", 64'h8080808080808080, 4'd1, 1'b1, stamp);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
